// File: rtl/bus_fabric_if.sv
// CPU-to-peripheral bus bundle: master-side request/response plus the
// broadcast slave-side address/data, one-hot strobes and per-slave responses.
interface bus_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [ADDR_W-1:0]            M_ADDR;
  logic [DATA_W-1:0]            M_DATA_I;
  logic [DATA_W-1:0]            M_DATA_O;
  logic                         M_WRSTB;
  logic                         M_RDSTB;
  logic                         M_READY;
  logic                         M_ERR;
  logic [ADDR_W-1:0]            S_ADDR;
  logic [DATA_W-1:0]            S_DATA_O;
  logic [NUM_SLAVES-1:0]        S_WRSTB;
  logic [NUM_SLAVES-1:0]        S_RDSTB;
  logic [NUM_SLAVES*DATA_W-1:0] S_DATA_I;
  logic [NUM_SLAVES-1:0]        S_READY;

  modport master (
    output M_ADDR, M_DATA_I, M_WRSTB, M_RDSTB,
    input  M_DATA_O, M_READY, M_ERR
  );

  modport slave (
    input  S_ADDR, S_DATA_O, S_WRSTB, S_RDSTB,
    output S_DATA_I, S_READY
  );

  modport fabric (
    input  M_ADDR, M_DATA_I, M_WRSTB, M_RDSTB,
    output M_DATA_O, M_READY, M_ERR,
    output S_ADDR, S_DATA_O, S_WRSTB, S_RDSTB,
    input  S_DATA_I, S_READY
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-master, multi-slave interconnect: registered decode, one-cycle slave
// strobes, wait-state handshake with timeout, and a saturating error counter.
module bus_fabric_dec #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = ((addr & MASK) == BASE);
endmodule

module bus_fabric #(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                           TIMEOUT    = 15
) (
  input  logic              ACLK,
  input  logic              RESET,
  bus_fabric_if.fabric      bus,
  output logic [15:0]       ERR_COUNT
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // A zero-width counter is illegal, so TIMEOUT=0 keeps a dormant 1-bit one.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                             state;
  logic [NUM_SLAVES-1:0]              hit;
  logic [IW-1:0]                      hit_idx;
  logic                               any_hit;
  logic [IW-1:0]                      idx;
  logic                               is_rd;
  logic                               err;
  logic [TW-1:0]                      tcnt;
  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_rdata;
  logic                               sel_ready;
  logic [DATA_W-1:0]                  sel_data;
  logic [NUM_SLAVES-1:0]              sel_oh;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
    bus_fabric_dec #(
      .ADDR_W (ADDR_W),
      .BASE   (SLAVE_BASE[i*ADDR_W +: ADDR_W]),
      .MASK   (SLAVE_MASK[i*ADDR_W +: ADDR_W])
    ) u_dec (
      .addr (bus.M_ADDR),
      .hit  (hit[i])
    );
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) hit_idx = IW'(i);
  end

  assign any_hit   = |hit;
  assign sel_oh    = NUM_SLAVES'(1) << hit_idx;
  assign s_rdata   = bus.S_DATA_I;
  assign sel_ready = bus.S_READY[idx];
  assign sel_data  = s_rdata[idx];

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      state        <= IDLE;
      idx          <= '0;
      is_rd        <= 1'b0;
      err          <= 1'b0;
      tcnt         <= '0;
      ERR_COUNT    <= '0;
      bus.M_DATA_O <= '0;
      bus.M_READY  <= 1'b0;
      bus.M_ERR    <= 1'b0;
      bus.S_ADDR   <= '0;
      bus.S_DATA_O <= '0;
      bus.S_WRSTB  <= '0;
      bus.S_RDSTB  <= '0;
    end else begin
      bus.S_WRSTB <= '0;
      bus.S_RDSTB <= '0;
      bus.M_READY <= 1'b0;
      bus.M_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.M_WRSTB || bus.M_RDSTB) begin
            bus.S_ADDR   <= bus.M_ADDR;
            bus.S_DATA_O <= bus.M_DATA_I;
            is_rd        <= bus.M_RDSTB;
            idx          <= hit_idx;
            if ((bus.M_WRSTB && bus.M_RDSTB) || !any_hit) begin
              err         <= 1'b1;
              bus.M_READY <= 1'b1;
              bus.M_ERR   <= 1'b1;
              if (bus.M_RDSTB) bus.M_DATA_O <= '0;
              state       <= RESP;
            end else begin
              err   <= 1'b0;
              tcnt  <= '0;
              if (bus.M_WRSTB) bus.S_WRSTB <= sel_oh;
              else             bus.S_RDSTB <= sel_oh;
              state <= ACCESS;
            end
          end
        end
        ACCESS, WAIT: begin
          if (sel_ready) begin
            bus.M_READY <= 1'b1;
            if (is_rd) bus.M_DATA_O <= sel_data;
            state       <= RESP;
          end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT)) begin
            err         <= 1'b1;
            bus.M_READY <= 1'b1;
            bus.M_ERR   <= 1'b1;
            if (is_rd) bus.M_DATA_O <= '0;
            state       <= RESP;
          end else begin
            if (TIMEOUT != 0) tcnt <= tcnt + 1'b1;
            state <= WAIT;
          end
        end
        RESP: begin
          if (err && ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// Directed vector bench for bus_fabric: four modelled slaves (two zero-wait,
// one with three wait cycles, one under bench control) and hand-written corners.
module tb_bus_fabric;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_fabric_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_fabric #(
    .NUM_SLAVES (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE ({32'h0000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT    (15)
  ) dut (
    .ACLK      (clk),
    .RESET     (rst),
    .bus       (bus),
    .ERR_COUNT (err_count)
  );

  // Slave models: 0 and 1 always ready, 2 ready 3 cycles after its strobe, 3 bench-driven.
  logic       s3_ready;
  logic [1:0] s2_cnt;
  always @(posedge clk) begin
    if (rst)                                  s2_cnt <= 2'd0;
    else if (bus.S_WRSTB[2] || bus.S_RDSTB[2]) s2_cnt <= 2'd1;
    else if (s2_cnt != 2'd0 && s2_cnt != 2'd3) s2_cnt <= s2_cnt + 2'd1;
    else                                      s2_cnt <= 2'd0;
  end
  assign bus.S_READY  = {s3_ready, (s2_cnt == 2'd3), 1'b1, 1'b1};
  assign bus.S_DATA_I = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_AAAA};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  int          r_lat;
  logic        r_err;
  logic [31:0] r_data;
  logic [3:0]  r_wr, r_rd;
  int          r_pulses;

  task automatic run(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    bus.M_ADDR = a; bus.M_DATA_I = d; bus.M_WRSTB = wr; bus.M_RDSTB = rd;
    r_lat = 0; r_err = 1'b0; r_data = '0; r_wr = '0; r_rd = '0; r_pulses = 0;
    @(posedge clk);
    for (int c = 1; c <= 40 && !got; c++) begin
      #1;
      r_wr |= bus.S_WRSTB;
      r_rd |= bus.S_RDSTB;
      r_pulses += $countones(bus.S_WRSTB) + $countones(bus.S_RDSTB);
      if (bus.M_READY) begin
        got = 1; r_lat = c; r_err = bus.M_ERR; r_data = bus.M_DATA_O;
      end else @(posedge clk);
    end
    if (!got) chk("ready_bound", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.M_WRSTB = 1'b0; bus.M_RDSTB = 1'b0;
  endtask

  typedef struct {
    logic        wr, rd;
    logic [31:0] addr, wdata;
    logic        s3rdy;
    int          lat;
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
    logic [3:0]  wr_oh, rd_oh;
    logic [15:0] errcnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0001_0004, 32'h0,         1'b0,  2, 1'b0, 1'b1, 32'hCAFE_F00D, 4'b0000, 4'b0010, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0002_0008, 32'h1234_5678, 1'b0,  5, 1'b0, 1'b1, 32'hCAFE_F00D, 4'b0100, 4'b0000, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0,         1'b0,  1, 1'b1, 1'b1, 32'h0,         4'b0000, 4'b0000, 16'd1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0,  2, 1'b0, 1'b1, 32'h0000_AAAA, 4'b0000, 4'b0001, 16'd1};
    vecs[4] = '{1'b0, 1'b1, 32'h0100_0000, 32'h0,         1'b1,  2, 1'b0, 1'b1, 32'h3333_3333, 4'b0000, 4'b1000, 16'd1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0,  2, 1'b0, 1'b1, 32'h3333_3333, 4'b0001, 4'b0000, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 32'h0002_0000, 32'h0,         1'b0,  5, 1'b0, 1'b1, 32'h2222_2222, 4'b0000, 4'b0100, 16'd1};
    vecs[7] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0055, 1'b0,  1, 1'b1, 1'b1, 32'h2222_2222, 4'b0000, 4'b0000, 16'd2};
    vecs[8] = '{1'b1, 1'b1, 32'h0001_0000, 32'h0000_0077, 1'b0,  1, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, 16'd3};
    vecs[9] = '{1'b0, 1'b1, 32'h0100_0004, 32'h0,         1'b0, 17, 1'b1, 1'b1, 32'h0,         4'b0000, 4'b1000, 16'd4};

    rst = 1'b1; s3_ready = 1'b0;
    bus.M_ADDR = '0; bus.M_DATA_I = '0; bus.M_WRSTB = 1'b0; bus.M_RDSTB = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", {bus.M_READY, bus.M_ERR, bus.M_DATA_O, bus.S_WRSTB, bus.S_RDSTB, err_count}, '0);
    chk("reset_bus", {bus.S_ADDR, bus.S_DATA_O}, '0);

    for (int v = 0; v < 10; v++) begin
      s3_ready = vecs[v].s3rdy;
      run(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("v%0d_latency", v), 64'(r_lat), 64'(vecs[v].lat));
      chk($sformatf("v%0d_err", v), 64'(r_err), 64'(vecs[v].err));
      if (vecs[v].chk_data) chk($sformatf("v%0d_rdata", v), 64'(r_data), 64'(vecs[v].rdata));
      chk($sformatf("v%0d_wrstb", v), 64'(r_wr), 64'(vecs[v].wr_oh));
      chk($sformatf("v%0d_rdstb", v), 64'(r_rd), 64'(vecs[v].rd_oh));
      chk($sformatf("v%0d_pulses", v), 64'(r_pulses), 64'($countones(vecs[v].wr_oh | vecs[v].rd_oh)));
      chk($sformatf("v%0d_saddr", v), 64'(bus.S_ADDR), 64'(vecs[v].addr));
      chk($sformatf("v%0d_sdata", v), 64'(bus.S_DATA_O), 64'(vecs[v].wdata));
      chk($sformatf("v%0d_errcnt", v), 64'(err_count), 64'(vecs[v].errcnt));
    end

    // Late ready from slave 3 after the timeout must not produce a response.
    @(negedge clk) s3_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("late_ready_ignored", {bus.M_READY, bus.S_RDSTB, bus.S_WRSTB}, '0);
    end
    @(negedge clk) s3_ready = 1'b0;
    chk("late_ready_errcnt", 64'(err_count), 64'd4);

    // Saturation of the error counter.
    @(negedge clk) force dut.ERR_COUNT = 16'hFFFE;
    @(negedge clk) release dut.ERR_COUNT;
    run(1'b1, 1'b1, 32'h0, 32'h0);
    chk("sat_first", 64'(err_count), 64'hFFFF);
    run(1'b0, 1'b1, 32'hF000_0000, 32'h0);
    run(1'b1, 1'b1, 32'h0, 32'h0);
    chk("sat_hold", 64'(err_count), 64'hFFFF);

    // Reset while waiting on slave 3.
    @(negedge clk);
    s3_ready = 1'b0; bus.M_ADDR = 32'h0100_0008; bus.M_DATA_I = 32'h9999_0000; bus.M_RDSTB = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("mid_state_wait", 64'(dut.state), 64'd2);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_outputs", {bus.M_READY, bus.M_ERR, bus.M_DATA_O, bus.S_WRSTB, bus.S_RDSTB, err_count}, '0);
    chk("mid_reset_bus", {bus.S_ADDR, bus.S_DATA_O}, '0);
    chk("mid_reset_state", 64'(dut.state), 64'd0);
    @(negedge clk) begin bus.M_RDSTB = 1'b0; s3_ready = 1'b1; end
    @(negedge clk) rst = 1'b0;
    run(1'b0, 1'b1, 32'h0001_0004, 32'h0);
    chk("post_reset_latency", 64'(r_lat), 64'd2);
    chk("post_reset_rdata", 64'(r_data), 64'hCAFE_F00D);
    chk("post_reset_err", 64'(r_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
